// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter
//   Shares one external memory bus between the instruction-fetch port and the
//   load/store port. One transaction is in flight at a time; the accepted
//   request is registered onto the bus and held until bus_ack, then a
//   one-cycle valid pulse goes back to the requester that won. Data accesses
//   win over fetches.
//
//   Optional feature macro: MEM_ARB_FAIRNESS_EN
//     defined   -> 4-bit starvation counter; after STARVE_LIMIT consecutive
//                  data grants with a fetch waiting, the fetch is forced through.
//     undefined -> strict data priority, STARVE_LIMIT has no effect.
//
// Ports
//   clock, reset                  core clock, async active-high reset
//   inst_req/addr                 fetch request (held until inst_ready)
//   inst_ready/valid/rdata        fetch accept, response pulse, fetched word
//   data_req/write/addr/wdata/wmask  load/store request (held until data_ready)
//   data_ready/valid/rdata        load/store accept, completion pulse, load word
//   bus_req/write/addr/wdata/wmask   registered bus transaction
//   bus_ack/rdata                 slave completion and read data
//
// States
//   IDLE      | no transaction; combinational arbitration, may grant this cycle
//   BUSY_INST | fetch on the bus, waiting for bus_ack
//   BUSY_DATA | load/store on the bus, waiting for bus_ack
module pipeline_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wmask,
  output logic        data_ready,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  output logic        bus_req,
  output logic        bus_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY_INST = 2'd1,
    BUSY_DATA = 2'd2
  } state_t;

  state_t state;
  logic   fetch_forced;
  logic   grant_data;
  logic   grant_inst;

  assign grant_data = (state == IDLE) && data_req && !fetch_forced;
  assign grant_inst = (state == IDLE) && inst_req && !grant_data;

  assign data_ready = grant_data;
  assign inst_ready = grant_inst;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;

  assign fetch_forced = inst_req && (starve_cnt == LIMIT);

  // Counts data grants that went ahead of a waiting fetch; any fetch grant,
  // or a data grant with no fetch pending, clears the run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else if (grant_inst) begin
      starve_cnt <= 4'd0;
    end else if (grant_data) begin
      if (!inst_req)
        starve_cnt <= 4'd0;
      else if (starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;
    end
  end
`else
  // Never true for a legal STARVE_LIMIT; strict data priority.
  assign fetch_forced = (STARVE_LIMIT < 0);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bus_req    <= 1'b0;
      bus_write  <= 1'b0;
      bus_addr   <= 32'd0;
      bus_wdata  <= 32'd0;
      bus_wmask  <= 4'd0;
      inst_valid <= 1'b0;
      inst_rdata <= 32'd0;
      data_valid <= 1'b0;
      data_rdata <= 32'd0;
    end else begin
      inst_valid <= 1'b0;
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_data) begin
            state     <= BUSY_DATA;
            bus_req   <= 1'b1;
            bus_write <= data_write;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
            bus_wmask <= data_wmask;
          end else if (grant_inst) begin
            state     <= BUSY_INST;
            bus_req   <= 1'b1;
            bus_write <= 1'b0;
            bus_addr  <= inst_addr;
            bus_wdata <= 32'd0;
            bus_wmask <= 4'd0;
          end
        end
        BUSY_INST: begin
          if (bus_ack) begin
            inst_rdata <= bus_rdata;
            inst_valid <= 1'b1;
            bus_req    <= 1'b0;
            state      <= IDLE;
          end
        end
        BUSY_DATA: begin
          if (bus_ack) begin
            // Stores leave the last load word in place.
            if (!bus_write)
              data_rdata <= bus_rdata;
            data_valid <= 1'b1;
            bus_req    <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          bus_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
module tb_pipeline_mem_arbiter;

  localparam int LIMIT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ready, inst_valid;
  logic [31:0] inst_rdata;
  logic        data_req, data_write;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wmask;
  logic        data_ready, data_valid;
  logic [31:0] data_rdata;
  logic        bus_req, bus_write;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  pipeline_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_ready(inst_ready),
    .inst_valid(inst_valid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_write(data_write), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wmask(data_wmask), .data_ready(data_ready),
    .data_valid(data_valid), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Slave memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : (a * 32'd3 + 32'h1000_0001);
  endfunction

  // ---------------- bus slave ----------------
  int ack_delay = 1;
  bit idle_ack_tog = 1'b0;
  bit seen_tog = 1'b0;
  int wait_cnt = 0;

  initial begin
    bus_ack = 1'b0;
    bus_rdata = 32'd0;
    forever begin
      @(posedge clock); #1;
      if (bus_ack) begin
        bus_ack = 1'b0;
        wait_cnt = 0;
      end
      if (idle_ack_tog != seen_tog) begin
        seen_tog = idle_ack_tog;
        bus_ack = 1'b1;
        bus_rdata = 32'hBAD0_BAD0;
      end else if (bus_req) begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          bus_ack = 1'b1;
          bus_rdata = mem_word(bus_addr);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
  } resp_t;

  resp_t       exp_q[$];
  logic [7:0]  grant_log[$];
  int          busy_log[$];
  logic [31:0] last_load = 32'd0;
  int          busy_len = 0;
  bit          prev_valid = 1'b0;
  int          ivalid_cnt = 0, dvalid_cnt = 0, fetch_on_dvalid = 0;
  logic        exp_bw;
  logic [31:0] exp_ba, exp_bd;
  logic [3:0]  exp_bm;

  initial begin
    resp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        last_load = 32'd0;
        busy_len = 0;
        prev_valid = 1'b0;
      end else begin
        if (bus_req) begin
          busy_len++;
          check_eq("ready_while_busy", {30'd0, inst_ready, data_ready}, 32'd0);
          check_eq("bus_write", bus_write, exp_bw);
          check_eq("bus_addr", bus_addr, exp_ba);
          check_eq("bus_wmask", bus_wmask, exp_bm);
          if (exp_bw) check_eq("bus_wdata", bus_wdata, exp_bd);
        end else if (busy_len != 0) begin
          busy_log.push_back(busy_len);
          busy_len = 0;
        end
        if (inst_valid || data_valid) begin
          check_eq("valid_back2back", prev_valid, 1'b0);
          if (exp_q.size() == 0) begin
            check_eq("unexpected_valid", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check_eq("resp_port", data_valid, e.is_data);
            check_eq("resp_rdata", data_valid ? data_rdata : inst_rdata, e.rdata);
          end
        end
        if (inst_valid) ivalid_cnt++;
        if (data_valid) dvalid_cnt++;
        if (inst_ready && data_valid) fetch_on_dvalid++;
        if (data_ready) begin
          grant_log.push_back("D");
          if (!data_write) last_load = mem_word(data_addr);
          exp_q.push_back('{1'b1, last_load});
          exp_bw = data_write; exp_ba = data_addr; exp_bd = data_wdata; exp_bm = data_wmask;
        end else if (inst_ready) begin
          grant_log.push_back("I");
          exp_q.push_back('{1'b0, mem_word(inst_addr)});
          exp_bw = 1'b0; exp_ba = inst_addr; exp_bd = 32'd0; exp_bm = 4'd0;
        end
        prev_valid = inst_valid | data_valid;
      end
    end
  end

  // ---------------- requester tasks ----------------
  task automatic do_fetch(input logic [31:0] a);
    int n = 0;
    inst_req = 1'b1;
    inst_addr = a;
    @(negedge clock);
    while (!inst_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (!inst_ready) check_eq("fetch_accept_timeout", 1'b1, 1'b0);
    @(posedge clock); #1;
    inst_req = 1'b0;
  endtask

  task automatic do_data(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    int n = 0;
    data_req = 1'b1;
    data_write = w; data_addr = a; data_wdata = d; data_wmask = m;
    @(negedge clock);
    while (!data_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (!data_ready) check_eq("data_accept_timeout", 1'b1, 1'b0);
    @(posedge clock); #1;
    data_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(posedge clock); #2;
      if (!bus_req && exp_q.size() == 0 && !inst_valid && !data_valid) break;
      if (++n > 300) begin
        check_eq("idle_timeout", 1'b1, 1'b0);
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int gi, bi, iv, dv, fd, n;
    logic [7:0] exp_order[6];

    reset = 1'b1;
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_write = 0; data_addr = 0; data_wdata = 0; data_wmask = 0;
    repeat (3) @(posedge clock);
    #3 reset = 1'b0;
    @(negedge clock);
    check_eq("rst_bus_req", bus_req, 1'b0);
    check_eq("rst_bus_write", bus_write, 1'b0);
    check_eq("rst_bus_addr", bus_addr, 32'd0);
    check_eq("rst_bus_wdata", bus_wdata, 32'd0);
    check_eq("rst_bus_wmask", bus_wmask, 4'd0);
    check_eq("rst_valids", {inst_valid, data_valid}, 2'b00);
    check_eq("rst_inst_rdata", inst_rdata, 32'd0);
    check_eq("rst_data_rdata", data_rdata, 32'd0);
    check_eq("rst_ready", {inst_ready, data_ready}, 2'b00);

    // Single fetch, ack one cycle after bus_req.
    @(posedge clock); #1;
    ack_delay = 1;
    inst_req = 1'b1; inst_addr = 32'h100;
    @(negedge clock);
    check_eq("c0_inst_ready", inst_ready, 1'b1);
    check_eq("c0_bus_req", bus_req, 1'b0);
    @(posedge clock); #1;
    inst_req = 1'b0;
    @(negedge clock);
    check_eq("c1_bus_req", bus_req, 1'b1);
    check_eq("c1_inst_valid", inst_valid, 1'b0);
    @(negedge clock);
    check_eq("c2_inst_valid", inst_valid, 1'b1);
    check_eq("c2_inst_rdata", inst_rdata, 32'h0000_0013);
    check_eq("c2_bus_req", bus_req, 1'b0);
    @(negedge clock);
    check_eq("c3_inst_valid", inst_valid, 1'b0);
    wait_idle();

    // Load to give data_rdata a known value, then simultaneous store + fetch.
    do_data(1'b0, 32'h300, 32'd0, 4'd0);
    wait_idle();
    check_eq("load_rdata", data_rdata, mem_word(32'h300));
    gi = grant_log.size(); fd = fetch_on_dvalid;
    fork
      do_fetch(32'h104);
      do_data(1'b1, 32'h2000, 32'hDEAD_BEEF, 4'hF);
    join
    wait_idle();
    check_eq("simul_first", grant_log[gi], "D");
    check_eq("simul_second", grant_log[gi+1], "I");
    check_eq("fetch_on_dvalid", fetch_on_dvalid - fd, 1);
    check_eq("store_keeps_rdata", data_rdata, mem_word(32'h300));

    // Ack delayed 5 cycles; fetch waits behind the store.
    ack_delay = 5;
    bi = busy_log.size(); iv = ivalid_cnt; dv = dvalid_cnt;
    fork
      do_fetch(32'h208);
      do_data(1'b1, 32'h40, 32'h1234_5678, 4'h3);
    join
    wait_idle();
    check_eq("delay_busy_data", busy_log[bi], 5);
    check_eq("delay_busy_inst", busy_log[bi+1], 5);
    check_eq("delay_dvalid_count", dvalid_cnt - dv, 1);
    check_eq("delay_ivalid_count", ivalid_cnt - iv, 1);

    // Continuous data stream with a waiting fetch.
    ack_delay = 1;
`ifdef MEM_ARB_FAIRNESS_EN
    exp_order = '{"D", "D", "I", "D", "D", "I"};
`else
    exp_order = '{"D", "D", "D", "D", "D", "D"};
`endif
    gi = grant_log.size();
    data_write = 1'b0; data_addr = 32'h500; inst_addr = 32'h600;
    data_req = 1'b1; inst_req = 1'b1;
    n = 0;
    forever begin
      @(posedge clock); #2;
      if (grant_log.size() >= gi + 6) break;
      if (++n > 200) begin
        check_eq("stream_timeout", 1'b1, 1'b0);
        break;
      end
    end
    data_req = 1'b0; inst_req = 1'b0;
    wait_idle();
    for (int i = 0; i < 6; i++)
      if (grant_log.size() > gi + i) check_eq("grant_order", grant_log[gi+i], exp_order[i]);

    // Reset in the middle of a BUSY_DATA wait.
    ack_delay = 50;
    do_data(1'b0, 32'h700, 32'd0, 4'd0);
    @(posedge clock);
    @(posedge clock); #3;
    dv = dvalid_cnt;
    check_eq("pre_rst_bus_req", bus_req, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("async_rst_bus_req", bus_req, 1'b0);
    check_eq("async_rst_bus_addr", bus_addr, 32'd0);
    check_eq("async_rst_data_rdata", data_rdata, 32'd0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    repeat (8) @(posedge clock);
    check_eq("no_dvalid_after_rst", dvalid_cnt - dv, 0);
    ack_delay = 2;
    @(posedge clock); #1;
    do_fetch(32'h108);
    wait_idle();
    check_eq("post_rst_fetch", inst_rdata, mem_word(32'h108));

    // bus_ack while idle.
    iv = ivalid_cnt; dv = dvalid_cnt;
    idle_ack_tog = ~idle_ack_tog;
    repeat (4) @(posedge clock);
    #2;
    check_eq("idle_ack_valids", (ivalid_cnt - iv) + (dvalid_cnt - dv), 0);
    check_eq("idle_ack_bus_req", bus_req, 1'b0);
    check_eq("idle_ack_inst_rdata", inst_rdata, mem_word(32'h108));
    do_data(1'b0, 32'h800, 32'd0, 4'd0);
    wait_idle();
    check_eq("after_idle_ack_load", data_rdata, mem_word(32'h800));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
